// File: rtl/axi4_rd_responder.sv
// AXI4 read-channel responder with an internal word memory and a preload port.
// One burst at a time; FIXED/INCR/WRAP; first beat READ_LATENCY cycles after AR.
// Optional build macro AXI_RD_RANGE_CHECK_EN: per-beat SLVERR for byte addresses
// outside [BASE_ADDR, BASE_ADDR + MEM_WORDS*DATA_WIDTH/8); otherwise the index wraps.
module axi4_rd_responder #(
   parameter int unsigned            ID_WIDTH     = 4,
   parameter int unsigned            ADDR_WIDTH   = 32,
   parameter int unsigned            DATA_WIDTH   = 32,
   parameter int unsigned            MEM_WORDS    = 4096,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR    = '0,
   parameter int unsigned            READ_LATENCY = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         ar_valid_i,
   output logic                         ar_ready_o,
   input  logic [ID_WIDTH-1:0]          ar_id_i,
   input  logic [ADDR_WIDTH-1:0]        ar_addr_i,
   input  logic [7:0]                   ar_len_i,
   input  logic [2:0]                   ar_size_i,
   input  logic [1:0]                   ar_burst_i,
   output logic                         r_valid_o,
   input  logic                         r_ready_i,
   output logic [ID_WIDTH-1:0]          r_id_o,
   output logic [DATA_WIDTH-1:0]        r_data_o,
   output logic [1:0]                   r_resp_o,
   output logic                         r_last_o,
   input  logic                         load_we_i,
   input  logic [$clog2(MEM_WORDS)-1:0] load_idx_i,
   input  logic [DATA_WIDTH-1:0]        load_data_i
);

   localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
   localparam int unsigned OFF_W    = $clog2(DATA_WIDTH/8);
   localparam logic [2:0]  SIZE_MAX = 3'(OFF_W);
   localparam int unsigned CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_ar_ready, r_valid, r_last, r_err;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [1:0]              r_resp, r_burst;
   logic [ID_WIDTH-1:0]     r_id;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [7:0]              r_len, r_beat;
   logic [2:0]              r_size;
   logic [CNT_W-1:0]        r_wcnt;
   logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

   logic                    w_ar_hs, w_first, w_r_hs, w_adv, w_done, w_load;
   logic                    w_beat_err, w_last_nxt;
   logic [ADDR_WIDTH-1:0]   w_beat_addr;
   logic [DATA_WIDTH-1:0]   w_rd_word;

   // Address of the beat following 'addr' for the captured burst type.
   function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                         input logic [2:0] size,
                                                         input logic [7:0] len,
                                                         input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] step, mask, inc;
      step = ADDR_WIDTH'(1) << size;
      mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      inc  = addr + step;
      case (burst)
         2'b01:   f_next_addr = inc;
         2'b10:   f_next_addr = (addr & ~mask) | (inc & mask);
         default: f_next_addr = addr;
      endcase
   endfunction

   // Whole-burst error: reserved type, oversize beat, illegal or misaligned WRAP.
   function automatic logic f_ar_err(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
      logic [ADDR_WIDTH-1:0] step;
      logic                  wrap_len_ok;
      step        = ADDR_WIDTH'(1) << size;
      wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      f_ar_err    = (burst == 2'b11) || (size > SIZE_MAX) ||
                    ((burst == 2'b10) && (!wrap_len_ok || ((addr & (step - ADDR_WIDTH'(1))) != '0)));
   endfunction

   // Word index; narrow sizes still read the full aligned word.
   function automatic logic [IDX_W-1:0] f_word_idx(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] off;
      off        = addr - BASE_ADDR;
      f_word_idx = IDX_W'(off >> OFF_W);
   endfunction

`ifdef AXI_RD_RANGE_CHECK_EN
   localparam logic [ADDR_WIDTH:0] RANGE_BYTES =
      (ADDR_WIDTH+1)'(longint'(MEM_WORDS) * longint'(DATA_WIDTH/8));

   // Byte address below BASE_ADDR wraps to a huge offset, so one compare covers both ends.
   function automatic logic f_out_of_range(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] off;
      off            = addr - BASE_ADDR;
      f_out_of_range = ({1'b0, off} >= RANGE_BYTES);
   endfunction
`endif

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (ar_valid_i && r_ar_ready) w_state_nxt = (READ_LATENCY == 1) ? S_BEAT : S_WAIT;
         S_WAIT: if (r_wcnt == CNT_W'(1))      w_state_nxt = S_BEAT;
         S_BEAT: if (r_valid && r_ready_i && r_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output/datapath decode: the first BEAT cycle fetches beat 0, each R handshake fetches the next.
   always_comb begin
      w_ar_hs     = (r_state == S_IDLE) && ar_valid_i && r_ar_ready;
      w_first     = (r_state == S_BEAT) && !r_valid;
      w_r_hs      = (r_state == S_BEAT) && r_valid && r_ready_i;
      w_adv       = w_r_hs && !r_last;
      w_done      = w_r_hs && r_last;
      w_load      = w_first || w_adv;
      w_beat_addr = w_first ? r_addr : f_next_addr(r_addr, r_size, r_len, r_burst);
`ifdef AXI_RD_RANGE_CHECK_EN
      w_beat_err  = r_err || f_out_of_range(w_beat_addr);
`else
      w_beat_err  = r_err;
`endif
      w_rd_word   = r_mem[f_word_idx(w_beat_addr)];
      w_last_nxt  = w_first ? (r_len == 8'd0) : ((r_beat + 8'd1) == r_len);
   end

   // Control and R-channel output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ar_ready <= 1'b0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_data     <= '0;
         r_resp     <= 2'b00;
         r_id       <= '0;
         r_beat     <= '0;
         r_wcnt     <= '0;
      end else begin
         r_ar_ready <= (w_state_nxt == S_IDLE);
         if (w_ar_hs) begin
            r_id   <= ar_id_i;
            r_beat <= '0;
            r_wcnt <= CNT_W'(READ_LATENCY - 1);
         end else if (r_state == S_WAIT) begin
            r_wcnt <= r_wcnt - CNT_W'(1);
         end
         if (w_adv) r_beat <= r_beat + 8'd1;
         if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_beat_err ? '0 : w_rd_word;
            r_resp  <= w_beat_err ? 2'b10 : 2'b00;
            r_last  <= w_last_nxt;
         end else if (w_done) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end
      end
   end

   // Burst attributes captured at AR; the address walks forward on each handshake.
   always_ff @(posedge clk_i) begin
      if (w_ar_hs) begin
         r_addr  <= ar_addr_i;
         r_len   <= ar_len_i;
         r_size  <= ar_size_i;
         r_burst <= ar_burst_i;
         r_err   <= f_ar_err(ar_addr_i, ar_len_i, ar_size_i, ar_burst_i);
      end else if (w_adv) begin
         r_addr  <= w_beat_addr;
      end
   end

   // Preload port; same-cycle reads see the old word.
   always_ff @(posedge clk_i) begin
      if (load_we_i) r_mem[load_idx_i] <= load_data_i;
   end

   assign ar_ready_o = r_ar_ready;
   assign r_valid_o  = r_valid;
   assign r_id_o     = r_id;
   assign r_data_o   = r_data;
   assign r_resp_o   = r_resp;
   assign r_last_o   = r_last;

endmodule

// File: doc/axi4_rd_responder.md
Name: axi4_rd_responder

Overview:
- AXI4 read-channel responder (slave end) with an internal word memory.
- Answers AR/R bursts issued by the core's fetch or L1 refill initiators, using the team's default AXI4 widths.
- Used as a fetch-side memory model in core-level benches and as a small boot ROM/RAM on FPGA.
- One burst outstanding at a time; INCR, WRAP and FIXED bursts; programmable first-beat latency.

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, R data width; power of 2, >=32
MEM_WORDS, 4096, memory depth in DATA_WIDTH words; power of 2
BASE_ADDR, 32'h0000_0000, byte address of word 0
READ_LATENCY, 2, cycles from AR handshake edge to first r_valid_o; >=1

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous assert, active-low
ar_valid_i  in  1  AR valid
ar_ready_o  out  1  AR ready
ar_id_i  in  ID_WIDTH  AR ID
ar_addr_i  in  ADDR_WIDTH  AR byte address
ar_len_i  in  8  beats minus 1
ar_size_i  in  3  log2 bytes per beat
ar_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
r_valid_o  out  1  R valid
r_ready_i  in  1  R ready
r_id_o  out  ID_WIDTH  echoed ID
r_data_o  out  DATA_WIDTH  read data
r_resp_o  out  2  00 OKAY, 10 SLVERR
r_last_o  out  1  final beat
load_we_i  in  1  preload write strobe
load_idx_i  in  $clog2(MEM_WORDS)  preload word index
load_data_i  in  DATA_WIDTH  preload data

Behaviour:
- Async reset values: ar_ready_o=0; r_valid_o, r_last_o, r_data_o, r_id_o, r_resp_o all 0; state IDLE. Memory contents are not reset.
- ar_ready_o is registered. It rises on the first posedge after reset release and stays 1 in IDLE.
- FSM states: IDLE, WAIT, BEAT.
- IDLE:
  - On ar_valid_i&&ar_ready_o, capture id/addr/len/size/burst, drop ar_ready_o next cycle, clear beat counter.
  - If READ_LATENCY=1, go to BEAT; otherwise go to WAIT with counter = READ_LATENCY-1.
- WAIT: decrement each cycle; enter BEAT when counter reaches 1.
- BEAT:
  - r_valid_o=1. r_data_o, r_resp_o and r_last_o are registered on beat entry and on each R handshake.
  - All R outputs hold stable while r_ready_i=0.
  - r_last_o=1 when beat counter equals captured len.
  - Handshake on the last beat returns to IDLE: r_valid_o=0 and ar_ready_o=1 the next cycle.
  - Minimum one idle cycle between bursts.
- Word index = ((addr-BASE_ADDR) >> log2(DATA_WIDTH/8)) mod MEM_WORDS. Narrow sizes return the full aligned word; the master selects byte lanes.
- Address update per handshake:
  - FIXED: unchanged.
  - INCR: addr += 1<<size, with 4KB crossing not checked.
  - WRAP: boundary = (len+1)<<size; addr = (addr & ~(boundary-1)) | ((addr + (1<<size)) & (boundary-1)).
- SLVERR for every beat, r_data_o=0, beat count and r_last still honoured, when any of:
  - burst=11;
  - size > log2(DATA_WIDTH/8);
  - WRAP with len not in {1,3,7,15};
  - WRAP with an unaligned start address.
- Load port writes on any cycle, including mid-burst. A load to the word being captured into r_data_o in the same cycle returns the old value (read-before-write).
- Reset mid-burst clears all outputs immediately. The burst is abandoned and no further R beats are issued.

Optional Feature:
AXI_RD_RANGE_CHECK_EN
- Defined: any beat whose byte address lies outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*DATA_WIDTH/8) returns SLVERR with data 0, evaluated per beat. In-range beats of the same burst return OKAY.
- Undefined: no range check; the index wraps modulo MEM_WORDS and the response is OKAY.

Test Plan:
- Preload word i = 0x1000_0000+i (i=0..15); AR addr 0x0, len 3, INCR, size 2, id 5, r_ready_i=1 -> first r_valid_o 2 cycles after the AR edge; data 0x10000000..0x10000003; id 5; OKAY; r_last_o only on beat 3.
- AR addr 0x38, len 15, WRAP, size 2 -> beat addresses 0x38, 0x3C, 0x00 ... 0x34; data words 14, 15, 0..13; last on beat 15.
- INCR len 3 with r_ready_i pattern 1,0,0,1,0,1,1 -> each beat held stable while stalled; exactly 4 handshakes; data in order; ar_ready_o=0 until the cycle after the last handshake.
- FIXED len 2 addr 0x8 -> three beats of word 2. burst=11 len 1 -> two SLVERR beats with data 0, last on beat 1. WRAP len 2 -> three SLVERR beats.
- Assert rst_ni low after beat 1 of a len 7 burst -> r_valid_o=0 asynchronously; ar_ready_o=1 one cycle after release; a new len 0 burst returns the correct word.
- AR addr BASE_ADDR+MEM_WORDS*4, len 0 -> with AXI_RD_RANGE_CHECK_EN: SLVERR, data 0; without: OKAY, data = word 0.
